traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker sitting on the outputs of the traffic-light controller (`Green`, `Yellow`, `Red`). It decodes the light lines back into a phase, measures each phase's duration in clock cycles and flags illegal encodings, wrong sequencing, and phases that are too short or too long. It is instantiated alongside the controller in benches and in the FPGA top for on-board self-check, and drives no control signals back into the controller.

## Interface
- `GREEN_CYCLES`, default 50: required green duration in cycles; legal range 1..126.
- `YELLOW_CYCLES`, default 10: required yellow duration in cycles; legal range 1..126.
- `RED_CYCLES`, default 40: required red duration in cycles; legal range 1..126.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `Green`, `Yellow`, `Red`  in  1 each: light lines from the controller, synchronous to `clk`.
- `phase`  out  2: tracked phase. 0 = none/unsynced, 1 = green, 2 = yellow, 3 = red.
- `phase_cnt`  out  7: cycles spent in the current phase, starting at 1; saturates at 127.
- `locked`  out  1: monitor has synchronised to a phase boundary.
- `err_onehot`  out  1: one-cycle pulse, light lines not exactly one-hot.
- `err_order`  out  1: one-cycle pulse, illegal transition.
- `err_short`  out  1: one-cycle pulse, phase ended before its required duration.
- `err_long`  out  1: one-cycle pulse, phase exceeded its required duration.
- `err_count`  out  8: saturating count of cycles with any error pulse.

## Operation
- Stage 1 registers the three light lines into a sample register every cycle. Stage 2 is the FSM below, operating on the registered sample. Stage 2 compares the current sample with the previous sample held in stage 2.
- Decode:
  - Exactly one line high gives the valid colour G, Y or R.
  - Any other combination (000, 011, 111, ...) is INVALID.
- States: SYNC, LOCKED.
- SYNC (`locked`=0, `phase`=0, `phase_cnt`=0):
  - Waits for the sample to change from the previous sample to a valid colour.
  - The first phase after reset or resync has unknown length, so it is ignored.
  - On that change: go to LOCKED, `phase` = new colour, `phase_cnt` = 1. No error is checked on this transition.
  - An INVALID sample in SYNC raises `err_onehot` and stays in SYNC.
- LOCKED, per registered sample:
  - INVALID: pulse `err_onehot`, go to SYNC (`phase`=0, `phase_cnt`=0, `locked`=0).
  - Same colour as `phase`: `phase_cnt` increments, saturating at 127. When `phase_cnt` goes from REQ to REQ+1 (REQ = parameter for the current colour), pulse `err_long`. It pulses exactly once per phase.
  - Different valid colour:
    - Legal order is G→Y, Y→R, R→G; any other transition pulses `err_order`.
    - If `phase_cnt` < REQ, pulse `err_short`.
    - In all cases load `phase` = new colour and `phase_cnt` = 1, and stay LOCKED. The monitor resyncs on the new colour.
- Simultaneous events:
  - `err_order` and `err_short` may pulse in the same cycle.
  - `err_count` increments by exactly 1 per cycle in which any `err_*` is high, and holds at 255.
- A phase with `phase_cnt` == REQ at the transition is correct: no error.

## Timing
- Reset asserted (`reset`=0), asynchronous:
  - Sample register cleared to 000.
  - State = SYNC; `phase`=0, `phase_cnt`=0, `locked`=0.
  - All `err_*` = 0; `err_count` = 0.
  - An all-zero previous sample counts as INVALID for change detection only; it does not raise `err_onehot`.
- Latency: a light change present before rising edge n is captured at edge n. The resulting `phase`, `phase_cnt`, `locked` and `err_*` values are visible after edge n+1. This is a fixed 2-cycle latency.
- Every `err_*` output is registered and high for exactly one cycle per event.
- A reset assertion mid-phase or mid-pulse clears everything immediately. After release, the monitor re-enters SYNC and needs one full phase boundary before `locked`=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Benches use `GREEN_CYCLES`=4, `YELLOW_CYCLES`=2, `RED_CYCLES`=3.
- **Nominal sequence.** Drive G×4, Y×2, R×3, repeated ×3.
  - `locked` goes to 1 two edges after the first boundary.
  - `phase` steps 1→2→3→1.
  - `phase_cnt` peaks at 4/2/3.
  - All `err_*` stay 0; `err_count`=0.
- **Short and long phases.** After lock, drive G×3 then Y×3.
  - `err_short` pulses once at the G→Y boundary.
  - `err_long` pulses once when Y's `phase_cnt` reaches 3.
  - `err_count`=2.
- **Order error.** After lock, drive G×4 then R×3.
  - `err_order` pulses once; `err_short` does not pulse.
  - `phase`=3 and `locked` stays 1.
  - The next R→G is accepted with no error.
- **Invalid encoding.** While locked, drive Green=1 and Red=1 for 1 cycle.
  - `err_onehot` pulses once.
  - `locked`=0 and `phase`=0.
  - Relock occurs only after the next valid colour change.
- **Saturation.** Hold G for 200 cycles.
  - `phase_cnt` stops at 127.
  - `err_long` pulses exactly once.
  - Separately, toggle invalid/valid 300 times: `err_count` holds at 255.
- **Reset mid-phase.** Pull `reset` low for 3 ns, off the clock edge, during Y.
  - All outputs are 0 immediately, before the next edge.
  - After release, no `err_*` pulses until the second boundary.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive checker on the traffic-light controller outputs: decodes the light
// lines into a phase, times each phase and flags encoding/order/duration errors.
module traffic_light_monitor #(
  parameter int GREEN_CYCLES  = 50,
  parameter int YELLOW_CYCLES = 10,
  parameter int RED_CYCLES    = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Green,
  input  logic       Yellow,
  input  logic       Red,
  output logic [1:0] phase,
  output logic [6:0] phase_cnt,
  output logic       locked,
  output logic       err_onehot,
  output logic       err_order,
  output logic       err_short,
  output logic       err_long,
  output logic [7:0] err_count
);

  typedef enum logic {SYNC, LOCKED} state_t;

  localparam logic [1:0] COL_NONE = 2'd0;
  localparam logic [1:0] COL_G    = 2'd1;
  localparam logic [1:0] COL_Y    = 2'd2;
  localparam logic [1:0] COL_R    = 2'd3;

  state_t     state;
  state_t     state_next;
  logic [2:0] sample;
  logic [2:0] prev_sample;
  logic       sample_ok;
  logic [1:0] cur_col;
  logic [1:0] prev_col;
  logic [6:0] req;
  logic       boundary;
  logic       legal_order;
  logic [1:0] phase_next;
  logic [6:0] cnt_next;
  logic       locked_next;
  logic       onehot_next;
  logic       order_next;
  logic       short_next;
  logic       long_next;
  logic [7:0] count_next;

  function automatic logic [1:0] decode(input logic [2:0] lines);
    case (lines)
      3'b100:  decode = COL_G;
      3'b010:  decode = COL_Y;
      3'b001:  decode = COL_R;
      default: decode = COL_NONE;
    endcase
  endfunction

  assign cur_col  = decode(sample);
  assign prev_col = decode(prev_sample);

  // A boundary needs a valid colour on both sides, so the cleared sample after
  // reset or an invalid encoding never counts as the start of a timed phase.
  assign boundary = (cur_col != COL_NONE) && (prev_col != COL_NONE) &&
                    (cur_col != prev_col);

  assign legal_order = ((phase == COL_G) && (cur_col == COL_Y)) ||
                       ((phase == COL_Y) && (cur_col == COL_R)) ||
                       ((phase == COL_R) && (cur_col == COL_G));

  always_comb begin
    case (phase)
      COL_G:   req = 7'(GREEN_CYCLES);
      COL_Y:   req = 7'(YELLOW_CYCLES);
      COL_R:   req = 7'(RED_CYCLES);
      default: req = 7'd0;
    endcase
  end

  // sample_ok masks the reset value of the sample register from err_onehot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample      <= 3'b000;
      prev_sample <= 3'b000;
      sample_ok   <= 1'b0;
    end else begin
      sample      <= {Green, Yellow, Red};
      prev_sample <= sample;
      sample_ok   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (boundary) state_next = LOCKED;
      LOCKED:  if (cur_col == COL_NONE) state_next = SYNC;
      default: state_next = SYNC;
    endcase
  end

  always_comb begin
    phase_next  = phase;
    cnt_next    = phase_cnt;
    onehot_next = 1'b0;
    order_next  = 1'b0;
    short_next  = 1'b0;
    long_next   = 1'b0;
    case (state)
      SYNC: begin
        phase_next = COL_NONE;
        cnt_next   = 7'd0;
        if (cur_col == COL_NONE) begin
          onehot_next = sample_ok;
        end else if (boundary) begin
          phase_next = cur_col;
          cnt_next   = 7'd1;
        end
      end
      LOCKED: begin
        if (cur_col == COL_NONE) begin
          onehot_next = 1'b1;
          phase_next  = COL_NONE;
          cnt_next    = 7'd0;
        end else if (cur_col == phase) begin
          if (phase_cnt != 7'd127) cnt_next = phase_cnt + 7'd1;
          long_next = (phase_cnt == req);
        end else begin
          order_next = !legal_order;
          short_next = (phase_cnt < req);
          phase_next = cur_col;
          cnt_next   = 7'd1;
        end
      end
      default: begin
        phase_next = COL_NONE;
        cnt_next   = 7'd0;
      end
    endcase
    locked_next = (state_next == LOCKED);
    count_next  = err_count;
    if ((onehot_next || order_next || short_next || long_next) &&
        (err_count != 8'hFF))
      count_next = err_count + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase      <= COL_NONE;
      phase_cnt  <= 7'd0;
      locked     <= 1'b0;
      err_onehot <= 1'b0;
      err_order  <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      phase      <= phase_next;
      phase_cnt  <= cnt_next;
      locked     <= locked_next;
      err_onehot <= onehot_next;
      err_order  <= order_next;
      err_short  <= short_next;
      err_long   <= long_next;
      err_count  <= count_next;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scoreboard bench for traffic_light_monitor with short phase
// requirements (G=4, Y=2, R=3); expectations are checked two edges after drive.
module tb_traffic_light_monitor;

  localparam logic [2:0] L_G   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_R   = 3'b001;
  localparam logic [2:0] L_GR  = 3'b101;
  localparam logic [2:0] L_ALL = 3'b111;

  typedef struct packed {
    logic [1:0] phase;
    logic [6:0] cnt;
    logic       locked;
    logic       e_onehot;
    logic       e_order;
    logic       e_short;
    logic       e_long;
    logic [7:0] count;
  } obs_t;

  typedef struct {
    int   due;
    obs_t exp;
    int   scen;
    int   step;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] lights;
  logic [1:0] phase;
  logic [6:0] phase_cnt;
  logic       locked;
  logic       err_onehot;
  logic       err_order;
  logic       err_short;
  logic       err_long;
  logic [7:0] err_count;
  obs_t       observed;

  entry_t sb[$];
  int     cyc       = 0;
  int     checks    = 0;
  int     errors    = 0;
  int     exp_count = 0;
  int     scen      = 0;
  int     step      = 0;

  traffic_light_monitor #(
    .GREEN_CYCLES (4),
    .YELLOW_CYCLES(2),
    .RED_CYCLES   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Green     (lights[2]),
    .Yellow    (lights[1]),
    .Red       (lights[0]),
    .phase     (phase),
    .phase_cnt (phase_cnt),
    .locked    (locked),
    .err_onehot(err_onehot),
    .err_order (err_order),
    .err_short (err_short),
    .err_long  (err_long),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb observed = {phase, phase_cnt, locked, err_onehot, err_order,
                          err_short, err_long, err_count};

  function automatic string scen_name(input int s);
    case (s)
      0:       scen_name = "nominal";
      1:       scen_name = "short_long";
      2:       scen_name = "order";
      3:       scen_name = "invalid";
      4:       scen_name = "saturation";
      default: scen_name = "reset_mid";
    endcase
  endfunction

  function automatic obs_t mk(input logic [1:0] ph, input int cnt, input logic lk,
                              input logic oh, input logic ord, input logic sh,
                              input logic lg, input int count);
    obs_t o;
    o.phase    = ph;
    o.cnt      = 7'(cnt);
    o.locked   = lk;
    o.e_onehot = oh;
    o.e_order  = ord;
    o.e_short  = sh;
    o.e_long   = lg;
    o.count    = 8'(count);
    return o;
  endfunction

  task automatic check_output(input obs_t exp, input string tag);
    checks++;
    assert (observed === exp) else begin
      errors++;
      $error("FAIL %s: got phase=%0d cnt=%0d locked=%0b err(oh,ord,sh,lg)=%b%b%b%b count=%0d, expected phase=%0d cnt=%0d locked=%0b err(oh,ord,sh,lg)=%b%b%b%b count=%0d",
             tag, observed.phase, observed.cnt, observed.locked, observed.e_onehot,
             observed.e_order, observed.e_short, observed.e_long, observed.count,
             exp.phase, exp.cnt, exp.locked, exp.e_onehot, exp.e_order,
             exp.e_short, exp.e_long, exp.count);
    end
  endtask

  // Results for a sample driven before edge n are visible after edge n+1.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      entry_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s step %0d: checked late at cycle %0d, required %0d",
                 scen_name(e.scen), e.step, cyc, e.due);
      end else begin
        check_output(e.exp, $sformatf("%s step %0d", scen_name(e.scen), e.step));
      end
    end
  end

  task automatic apply_stimulus(input logic [2:0] l, input obs_t exp);
    entry_t e;
    lights = l;
    e.due  = cyc + 2;
    e.exp  = exp;
    e.scen = scen;
    e.step = step;
    sb.push_back(e);
    step++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bump_count();
    if (exp_count < 255) exp_count++;
  endtask

  task automatic phase_run(input logic [2:0] l, input int n, input logic [1:0] ph,
                           input int cnt0, input logic lk, input logic e_ord,
                           input logic e_sh, input int long_at);
    for (int i = 0; i < n; i++) begin
      logic ord;
      logic sh;
      logic lg;
      int   c;
      ord = (i == 0) && e_ord;
      sh  = (i == 0) && e_sh;
      lg  = (i == long_at);
      c   = (cnt0 + i > 127) ? 127 : cnt0 + i;
      if (ord || sh || lg) bump_count();
      if (lk) apply_stimulus(l, mk(ph, c, 1'b1, 1'b0, ord, sh, lg, exp_count));
      else    apply_stimulus(l, mk(2'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count));
    end
  endtask

  task automatic invalid_step(input logic [2:0] l);
    bump_count();
    apply_stimulus(l, mk(2'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_count));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset  = 1'b0;
    lights = L_G;
    repeat (2) @(negedge clk);
    check_output(mk(2'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0), "reset_state");
    reset = 1'b1;

    // The first green after reset is of unknown length and stays unlocked.
    scen = 0;
    phase_run(L_G, 4, 2'd0, 0, 1'b0, 1'b0, 1'b0, -1);
    phase_run(L_Y, 2, 2'd2, 1, 1'b1, 1'b0, 1'b0, -1);
    phase_run(L_R, 3, 2'd3, 1, 1'b1, 1'b0, 1'b0, -1);
    for (int r = 0; r < 2; r++) begin
      phase_run(L_G, 4, 2'd1, 1, 1'b1, 1'b0, 1'b0, -1);
      phase_run(L_Y, 2, 2'd2, 1, 1'b1, 1'b0, 1'b0, -1);
      phase_run(L_R, 3, 2'd3, 1, 1'b1, 1'b0, 1'b0, -1);
    end

    scen = 1;
    phase_run(L_G, 3, 2'd1, 1, 1'b1, 1'b0, 1'b0, -1);
    phase_run(L_Y, 3, 2'd2, 1, 1'b1, 1'b0, 1'b1, 2);
    phase_run(L_R, 3, 2'd3, 1, 1'b1, 1'b0, 1'b0, -1);

    scen = 2;
    phase_run(L_G, 4, 2'd1, 1, 1'b1, 1'b0, 1'b0, -1);
    phase_run(L_R, 3, 2'd3, 1, 1'b1, 1'b1, 1'b0, -1);
    phase_run(L_G, 4, 2'd1, 1, 1'b1, 1'b0, 1'b0, -1);

    scen = 3;
    invalid_step(L_GR);
    phase_run(L_G, 3, 2'd0, 0, 1'b0, 1'b0, 1'b0, -1);
    phase_run(L_Y, 2, 2'd2, 1, 1'b1, 1'b0, 1'b0, -1);
    phase_run(L_R, 3, 2'd3, 1, 1'b1, 1'b0, 1'b0, -1);

    scen = 4;
    phase_run(L_G, 200, 2'd1, 1, 1'b1, 1'b0, 1'b0, 4);
    for (int t = 0; t < 300; t++) begin
      invalid_step(L_ALL);
      phase_run(L_G, 1, 2'd0, 0, 1'b0, 1'b0, 1'b0, -1);
    end
    phase_run(L_Y, 2, 2'd2, 1, 1'b1, 1'b0, 1'b0, -1);

    // Short asynchronous reset pulse in the low half of the clock, mid-yellow.
    scen = 5;
    #1 reset = 1'b0;
    sb.delete();
    exp_count = 0;
    #1 check_output(mk(2'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0), "reset_async");
    #2 reset = 1'b1;
    phase_run(L_Y, 1, 2'd0, 0, 1'b0, 1'b0, 1'b0, -1);
    phase_run(L_R, 2, 2'd3, 1, 1'b1, 1'b0, 1'b0, -1);
    phase_run(L_G, 4, 2'd1, 1, 1'b1, 1'b0, 1'b1, -1);

    repeat (3) @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
